// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet width, VC bit position and VC encodings.
package noc_pkg;
    localparam int PKT_W  = 64;
    localparam int VC_BIT = 63;

    typedef logic [PKT_W-1:0] pkt_t;

    localparam logic VC_EVEN = 1'b0;
    localparam logic VC_ODD  = 1'b1;
endpackage

// File: rtl/vc_slot.sv
// One-entry packet buffer with a full flag, driven by write and clear strobes.
module vc_slot
    import noc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic wr,
    input  logic clr,
    input  pkt_t din,
    output logic full,
    output pkt_t dout
);
    logic full_reg;
    pkt_t data_reg;

    // Data is only reloaded on a write; a clear leaves the last contents visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_reg <= 1'b0;
            data_reg <= '0;
        end else if (wr) begin
            full_reg <= 1'b1;
            data_reg <= din;
        end else if (clr) begin
            full_reg <= 1'b0;
        end
    end

    assign full = full_reg;
    assign dout = data_reg;
endmodule

// File: rtl/router_local_port.sv
// Router endpoint of the NIC link with polarity-multiplexed even/odd VC slots.
// Optional ROUTER_PORT_ERR_CNT_EN adds a saturating dropped-packet counter err_cnt.
module router_local_port
    import noc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    output logic             net_polarity,
    input  logic             net_so,
    output logic             net_ro,
    input  logic [PKT_W-1:0] net_do,
    output logic             net_si,
    input  logic             net_ri,
    output logic [PKT_W-1:0] net_di,
    output logic             ing_valid,
    input  logic             ing_ready,
    output logic [PKT_W-1:0] ing_data,
    input  logic             egr_valid,
    output logic             egr_ready,
    input  logic [PKT_W-1:0] egr_data,
`ifdef ROUTER_PORT_ERR_CNT_EN
    output logic [15:0]      err_cnt,
`endif
    output logic             err_vc
);
    logic       pol_reg;
    logic       ext_vc;
    logic       err_vc_reg;
    logic [1:0] ib_wr, ib_clr, ib_full;
    logic [1:0] eb_wr, eb_clr, eb_full;
    pkt_t       ib_data [2];
    pkt_t       eb_data [2];
    logic       net_xfer, vc_match, ing_take, ing_drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pol_reg <= 1'b0;
        end else begin
            pol_reg <= ~pol_reg;
        end
    end

    // The link always talks about the opposite VC to the one the core sees.
    assign ext_vc       = ~pol_reg;
    assign net_polarity = pol_reg;

    assign net_ro    = ~ib_full[ext_vc];
    assign net_xfer  = net_so & net_ro;
    assign vc_match  = (net_do[VC_BIT] == ext_vc);
    assign ing_take  = net_xfer & vc_match;
    assign ing_drop  = net_xfer & ~vc_match;

    assign ing_valid = ib_full[pol_reg];
    assign ing_data  = ib_data[pol_reg];

    assign egr_ready = ~eb_full[pol_reg] & (egr_data[VC_BIT] == pol_reg);
    assign net_si    = eb_full[ext_vc] & net_ri;
    assign net_di    = eb_data[ext_vc];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign ib_wr[gi]  = ing_take & (ext_vc == 1'(gi));
            assign ib_clr[gi] = ing_valid & ing_ready & (pol_reg == 1'(gi));
            assign eb_wr[gi]  = egr_valid & egr_ready & (pol_reg == 1'(gi));
            assign eb_clr[gi] = net_si & (ext_vc == 1'(gi));

            vc_slot u_ib (
                .clk   (clk),
                .reset (reset),
                .wr    (ib_wr[gi]),
                .clr   (ib_clr[gi]),
                .din   (net_do),
                .full  (ib_full[gi]),
                .dout  (ib_data[gi])
            );

            vc_slot u_eb (
                .clk   (clk),
                .reset (reset),
                .wr    (eb_wr[gi]),
                .clr   (eb_clr[gi]),
                .din   (egr_data),
                .full  (eb_full[gi]),
                .dout  (eb_data[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_vc_reg <= 1'b0;
        end else begin
            err_vc_reg <= ing_drop;
        end
    end

    assign err_vc = err_vc_reg;

`ifdef ROUTER_PORT_ERR_CNT_EN
    logic [15:0] err_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_reg <= 16'h0000;
        end else if (ing_drop && (err_cnt_reg != 16'hFFFF)) begin
            err_cnt_reg <= err_cnt_reg + 16'h0001;
        end
    end

    assign err_cnt = err_cnt_reg;
`endif
endmodule

// File: doc/router_local_port.md
# router_local_port

Router-side endpoint of the NIC link: the counterpart of the NIC's net_* interface. It buffers packets arriving from the NIC (net_so/net_ro/net_do) and delivers them to the router core. It buffers packets from the router core and sends them to the NIC (net_si/net_ri/net_di). It generates net_polarity, which time-multiplexes even and odd virtual channels (VCs) between the external link and the internal core.

## Interface
- PKT_W, 64, packet width
- VC_BIT, 63, packet bit carrying the VC (0 = even, 1 = odd)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- net_polarity  out  1  current phase, toggles every cycle
- net_so  in  1  NIC has a packet on net_do
- net_ro  out  1  router can accept a NIC packet this cycle
- net_do  in  PKT_W  packet from NIC
- net_si  out  1  router presents a packet on net_di
- net_ri  in  1  NIC input buffer ready
- net_di  out  PKT_W  packet to NIC
- ing_valid  out  1  ingress packet available to core
- ing_ready  in  1  core consumes ingress packet
- ing_data  out  PKT_W  ingress packet
- egr_valid  in  1  core offers egress packet
- egr_ready  out  1  egress slot free
- egr_data  in  PKT_W  egress packet
- err_vc  out  1  one-cycle pulse: a NIC packet with the wrong VC was dropped

## Operation
- pol register: reset value 0, inverted every cycle. net_polarity = pol.
- External VC is ~pol. Internal (core) VC is pol.
- Four one-entry slots: ib[0..1] for ingress and eb[0..1] for egress, each with a full flag.
- Ingress link side:
  - net_ro = ~ib_full[~pol].
  - Transfer when net_so & net_ro.
  - If net_do[VC_BIT] == ~pol, write ib[~pol] and set its full flag.
  - Otherwise drop the packet, leave the slot unchanged, and pulse err_vc on the next cycle.
- Ingress core side:
  - ing_valid = ib_full[pol], ing_data = ib[pol].
  - ing_valid & ing_ready clears the full flag.
- Egress core side:
  - egr_ready = ~eb_full[pol] & (egr_data[VC_BIT] == pol).
  - egr_valid & egr_ready writes eb[pol].
  - A mismatched-VC offer is stalled, not dropped.
- Egress link side:
  - net_si = eb_full[~pol] & net_ri, net_di = eb[~pol].
  - When net_si is high, the slot is cleared at the edge. The NIC treats net_si as a completed transfer.
- Link and core phases always address opposite slots, so no slot is read and written in the same cycle. Full and empty are per slot. There is no wrap-around.
- When reset is asserted mid-transfer, all packets are discarded, pol = 0, all full flags = 0.

## Timing
- Reset values: net_polarity 0, net_ro 1, net_si 0, net_di 0, ing_valid 0, ing_data 0, egr_ready 0 (until egr_data is even-VC), err_vc 0.
- Latency from NIC to core: a packet accepted in a cycle with pol=p is presented on ing_valid in the next cycle (pol=~p=VC), i.e. 1 cycle minimum.
- Latency from core to NIC: a packet written at pol=p is presented on net_si at the next cycle, 1 cycle minimum.
- Combinational paths:
  - net_si depends combinationally on net_ri.
  - egr_ready depends combinationally on egr_data[VC_BIT].
  - net_ro and ing_valid depend only on registers.
- net_di and ing_data hold the last slot contents when not valid. The cleared slot data is don't-care except at reset (0).
- net_so while net_ro=0 is ignored. The NIC keeps its packet and retries.

## Configuration
- ROUTER_PORT_ERR_CNT_EN defined:
  - Adds output port err_cnt[15:0], reset 0.
  - err_cnt increments on every dropped wrong-VC packet and saturates at 16'hFFFF.
- ROUTER_PORT_ERR_CNT_EN undefined:
  - Port absent, no counter logic.
  - err_vc still present.

## Structure
- Shared package noc_pkg: PKT_W, VC_BIT, pkt_t (logic [PKT_W-1:0]), VC_EVEN/VC_ODD constants.
- Sub-module vc_slot: one-entry register with full flag, write/clear strobes, and asynchronous active-low reset. Instantiated four times.
- The top level holds pol, the steering muxes, the handshakes, err_vc, and the optional counter.

## Test plan
- Reset check: hold reset low for 2 cycles and release. Require net_polarity 0 then 1 then 0…, net_ro=1, net_si=0, ing_valid=0.
- Ingress transfer: at pol=0, drive net_so=1 with net_do=64'h8EDCBA9876543210 (VC 1). Next cycle (pol=1), require ing_valid=1 and ing_data=64'h8EDCBA9876543210. Pulse ing_ready and require ing_valid=0 afterwards.
- Wrong VC: at pol=0, send 64'h000000000000000E (VC 0). Require the packet dropped, err_vc pulse, ib empty, and err_cnt=1 with the macro defined.
- Egress to NIC: at pol=0, core offers 64'h0BCD1234567890FF (VC 0) with egr_valid=1 and net_ri=1. Require egr_ready=1. Next cycle, require net_si=1 and net_di=64'h0BCD1234567890FF.
- NIC busy: with eb[1] full, hold net_ri=0 for 4 cycles. Require net_si=0 throughout and egr_ready=0 for VC 1 offers. On net_ri=1 at the matching phase, require exactly one net_si pulse.
- Full buffer backpressure: fill ib[1] and hold ing_ready=0. Require net_ro=0 on every pol=0 cycle and a second NIC packet not accepted. Then assert ing_ready and require net_ro=1 at the next pol=0.
